// File: rtl/pulse_queue.sv
// ---------------------------------------------------------------------------
// pulse_queue
//
// Multi-outstanding pulse delay / stretcher.
//
// Every rising edge of inp_i is timestamped against a free-running tick
// counter.  The time at which the matching output pulse must start
// (edge time + effective delay) is pushed into a small FIFO.  The oldest
// entry (the FIFO head) is compared against the counter.  When it comes due,
// a pulse of the effective width is launched on out_o.
//
// Ports
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   inp_i         trigger input; rising edges are queued
//   enable_i      block enable; low flushes the queue and the output
//   delay_i       edge-to-pulse delay in ticks; values below 4 act as 4
//   delay_wstb_i  delay_i written this cycle (flushes)
//   width_i       pulse width in ticks; 0 acts as 1
//   width_wstb_i  width_i written this cycle (flushes)
//   out_o         pulse output (registered)
//   perr_o        sticky: a pulse came due while out_o was still high
//   ovf_o         sticky: an edge arrived with the queue full
//   queued_o      number of pending entries
//   missed_cnt_o  dropped pulses (either cause), saturating
//
// Timing model
//   Cycle n is the cycle in which the counter holds n.  An edge seen in
//   cycle n stores n + delay_eff.  The output is a flop.  So an entry is
//   "fired" (and popped) in the cycle before it is due, by comparing it
//   with ts + 1.  out_o is then high from cycle n + delay_eff for
//   width_eff cycles.  The head is a registered FWFT copy of the oldest
//   entry.  It is valid one cycle after the push.  The minimum delay of 4
//   leaves slack between that point and the first compare that matters.
// ---------------------------------------------------------------------------
module pulse_queue #(
  parameter int TS_WIDTH    = 48,
  parameter int QUEUE_DEPTH = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         inp_i,
  input  logic                         enable_i,
  input  logic [TS_WIDTH-1:0]          delay_i,
  input  logic                         delay_wstb_i,
  input  logic [TS_WIDTH-1:0]          width_i,
  input  logic                         width_wstb_i,
  output logic                         out_o,
  output logic                         perr_o,
  output logic                         ovf_o,
  output logic [$clog2(QUEUE_DEPTH):0] queued_o,
  output logic [CNT_WIDTH-1:0]         missed_cnt_o
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  localparam logic [TS_WIDTH-1:0]  TS_ONE     = TS_WIDTH'(1);
  localparam logic [TS_WIDTH-1:0]  MIN_DELAY  = TS_WIDTH'(4);
  localparam logic [TS_WIDTH-1:0]  MIN_WIDTH  = TS_WIDTH'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE    = PTR_W'(1);
  localparam logic [COUNT_W-1:0]   COUNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0]   DEPTH_C    = COUNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_WIDTH-1:0] MISSED_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MISSED_MAX = '1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [TS_WIDTH-1:0]  ts_q,        ts_d;
  logic                 inp_prev_q,  inp_prev_d;
  logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
  logic [COUNT_W-1:0]   count_q,     count_d;
  logic [TS_WIDTH-1:0]  head_q,      head_d;
  logic                 out_q,       out_d;
  logic [TS_WIDTH-1:0]  rem_q,       rem_d;
  logic                 perr_q,      perr_d;
  logic                 ovf_q,       ovf_d;
  logic [CNT_WIDTH-1:0] missed_q,    missed_d;

  // Due-time storage.  Written at the tail; read at the next head position.
  logic [TS_WIDTH-1:0]  mem_q [QUEUE_DEPTH];
  logic                 mem_we_d;
  logic [TS_WIDTH-1:0]  mem_wdata_d;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  logic                flush;
  logic                edge_det;
  logic                head_valid;
  logic                full;
  logic                fire;
  logic                push;
  logic                drop;
  logic                collide;
  logic                miss;
  logic [TS_WIDTH-1:0] delay_eff;
  logic [TS_WIDTH-1:0] width_eff;
  logic [TS_WIDTH-1:0] push_val;

  // A register write or a disable discards all pending work.  That keeps
  // every queued entry consistent with the delay that is currently set.
  assign flush      = delay_wstb_i | width_wstb_i | ~enable_i;
  assign edge_det   = inp_i & ~inp_prev_q;

  assign delay_eff  = (delay_i < MIN_DELAY) ? MIN_DELAY : delay_i;
  assign width_eff  = (width_i < MIN_WIDTH) ? MIN_WIDTH : width_i;
  assign push_val   = ts_q + delay_eff;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == DEPTH_C);

  // Compare against ts + 1 so that the registered output rises exactly on
  // the due cycle.  Entries are strictly increasing, so only the head needs
  // a comparator.  Plain equality on TS_WIDTH bits handles counter wrap.
  assign fire       = ~flush & head_valid & (head_q == (ts_q + TS_ONE));

  // A full queue that is popping this cycle still has room for the edge.
  assign push       = ~flush & edge_det & (~full | fire);
  assign drop       = ~flush & edge_det & full & ~fire;

  // The entry is consumed even if the output cannot take it.
  assign collide    = fire & out_q;

  // collide implies a pop and drop implies no pop.  So at most one miss
  // can happen per cycle.
  assign miss       = collide | drop;

  // -------------------------------------------------------------------------
  // Free-running timestamp and edge-detect history
  // -------------------------------------------------------------------------
  always_comb begin
    ts_d       = ts_q + TS_ONE;
    inp_prev_d = inp_i;
  end

  // -------------------------------------------------------------------------
  // FIFO pointers, occupancy and registered head
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    head_d      = head_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = push_val;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we_d = push;

      if (fire) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      case ({push, fire})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase

      // The next head either already sits in storage, or it is the entry
      // being written this cycle.  That is the case when the read pointer
      // lands on the current tail slot.  A full queue can never reach this
      // branch without a pop, so rd_ptr_d == wr_ptr_q really means
      // "the queue is empty apart from the new entry".
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        head_d = push_val;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pulse generator
  // -------------------------------------------------------------------------
  // rem_q counts the high cycles still owed, including the current one.
  always_comb begin
    out_d = out_q;
    rem_d = rem_q;

    if (flush) begin
      out_d = 1'b0;
      rem_d = '0;
    end else if (out_q) begin
      rem_d = rem_q - TS_ONE;
      out_d = (rem_q != TS_ONE);
    end else if (fire) begin
      out_d = 1'b1;
      rem_d = width_eff;
    end
  end

  // -------------------------------------------------------------------------
  // Error flags and missed-pulse counter
  // -------------------------------------------------------------------------
  always_comb begin
    perr_d   = perr_q | collide;
    ovf_d    = ovf_q | drop;
    missed_d = missed_q;

    if (miss && (missed_q != MISSED_MAX)) begin
      missed_d = missed_q + MISSED_ONE;
    end

    if (flush) begin
      perr_d   = 1'b0;
      ovf_d    = 1'b0;
      missed_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ts_q       <= '0;
      inp_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      out_q      <= 1'b0;
      rem_q      <= '0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      missed_q   <= '0;
    end else begin
      ts_q       <= ts_d;
      inp_prev_q <= inp_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      out_q      <= out_d;
      rem_q      <= rem_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
      missed_q   <= missed_d;
    end
  end

  // Storage carries no reset.  Occupancy alone decides what is valid, so
  // stale contents after a reset or a flush are never compared.
  always_ff @(posedge clk_i) begin
    if (mem_we_d && !reset_i) begin
      mem_q[wr_ptr_q] <= mem_wdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_o        = out_q;
  assign perr_o       = perr_q;
  assign ovf_o        = ovf_q;
  assign queued_o     = count_q;
  assign missed_cnt_o = missed_q;

endmodule

// File: tb/tb_pulse_queue.sv
// ---------------------------------------------------------------------------
// tb_pulse_queue
//
// Uses a narrow timestamp, so the counter wraps many times during the run.
// It also uses a small queue and a small missed counter, so overflow and
// saturation are reached quickly.
//
// The reference model works in absolute (unbounded) cycle numbers.  It keeps
// a queue of due times and one current pulse, given as a start cycle and a
// width.
//
// Model cycle t is the cycle whose inputs are sampled at the next posedge.
// The outputs that are read at the following negedge belong to cycle t+1.
// ---------------------------------------------------------------------------
module tb_pulse_queue;

  localparam int TSW = 10;
  localparam int QD  = 4;
  localparam int CW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_r = 1'b1;
  logic           inp_r   = 1'b0;
  logic           enable_r = 1'b1;
  logic [TSW-1:0] delay_r = TSW'(5);
  logic           dwstb_r = 1'b0;
  logic [TSW-1:0] width_r = TSW'(1);
  logic           wwstb_r = 1'b0;

  logic             out_w;
  logic             perr_w;
  logic             ovf_w;
  logic [$clog2(QD):0] queued_w;
  logic [CW-1:0]    missed_w;

  pulse_queue #(
    .TS_WIDTH    (TSW),
    .QUEUE_DEPTH (QD),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_r),
    .inp_i        (inp_r),
    .enable_i     (enable_r),
    .delay_i      (delay_r),
    .delay_wstb_i (dwstb_r),
    .width_i      (width_r),
    .width_wstb_i (wwstb_r),
    .out_o        (out_w),
    .perr_o       (perr_w),
    .ovf_o        (ovf_w),
    .queued_o     (queued_w),
    .missed_cnt_o (missed_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_cyc = 0;
  longint m_due[$];
  longint m_start = -100000;
  longint m_w = 0;
  bit     m_prev = 1'b0;
  bit     m_perr = 1'b0;
  bit     m_ovf = 1'b0;
  int     m_missed = 0;

  function automatic void model_miss();
    if (m_missed < (1 << CW) - 1) m_missed++;
  endfunction

  function automatic void model_step();
    longint de;
    longint we;
    longint due;
    bit     rise;
    bit     flush;
    de = (delay_r < 4) ? 4 : longint'(delay_r);
    we = (width_r == 0) ? 1 : longint'(width_r);
    if (reset_r) begin
      m_due.delete();
      m_w = 0;
      m_perr = 1'b0;
      m_ovf = 1'b0;
      m_missed = 0;
      m_prev = 1'b0;
    end else begin
      rise  = inp_r && !m_prev;
      flush = dwstb_r || wwstb_r || !enable_r;
      if (flush) begin
        m_due.delete();
        m_w = 0;
        m_perr = 1'b0;
        m_ovf = 1'b0;
        m_missed = 0;
      end else begin
        // The entry due next cycle leaves the queue now.
        if (m_due.size() > 0 && m_due[0] == m_cyc + 1) begin
          due = m_due.pop_front();
          // A pulse is lost when the current one is at least as wide as
          // the spacing between the two start times.
          if (due - m_start <= m_w) begin
            m_perr = 1'b1;
            model_miss();
          end else begin
            m_start = due;
            m_w = we;
          end
        end
        if (rise) begin
          if (m_due.size() < QD) m_due.push_back(m_cyc + de);
          else begin
            m_ovf = 1'b1;
            model_miss();
          end
        end
      end
      m_prev = inp_r;
    end
    m_cyc++;
  endfunction

  // One clock: the model advances at the edge, and all outputs are compared
  // at the following negedge.
  task automatic tick();
    bit exp_out;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_out = (m_start <= m_cyc) && (m_cyc < m_start + m_w);
    check_val("out",    64'(out_w),    64'(exp_out));
    check_val("queued", 64'(queued_w), 64'(m_due.size()));
    check_val("perr",   64'(perr_w),   64'(m_perr));
    check_val("ovf",    64'(ovf_w),    64'(m_ovf));
    check_val("missed", 64'(missed_w), 64'(m_missed));
  endtask

  task automatic program_regs(input int d, input int w);
    delay_r = TSW'(d);
    dwstb_r = 1'b1;
    tick();
    dwstb_r = 1'b0;
    width_r = TSW'(w);
    wwstb_r = 1'b1;
    tick();
    wwstb_r = 1'b0;
    tick();
  endtask

  initial begin
    int hi;
    int first;

    // Reset state
    repeat (3) tick();
    check_val("rst_out",    64'(out_w),    64'd0);
    check_val("rst_queued", 64'(queued_w), 64'd0);
    check_val("rst_perr",   64'(perr_w),   64'd0);
    check_val("rst_ovf",    64'(ovf_w),    64'd0);
    check_val("rst_missed", 64'(missed_w), 64'd0);
    reset_r = 1'b0;
    tick();

    // Single edge, delay 5, width 10
    program_regs(5, 10);
    hi = 0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      inp_r = (k == 1);
      tick();
      if (out_w === 1'b1) begin
        hi++;
        if (first < 0) first = k;
      end
    end
    check_val("single_rise", 64'(first), 64'd5);
    check_val("single_width", 64'(hi), 64'd10);
    check_val("single_queued", 64'(queued_w), 64'd0);
    $display("txn single_edge rise_at %0d width %0d", first, hi);

    // Overlap: delay 10, width 20, edges 5 apart
    program_regs(10, 20);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      inp_r = (k == 0) || (k == 5);
      tick();
      if (out_w === 1'b1) hi++;
    end
    check_val("overlap_width", 64'(hi), 64'd20);
    check_val("overlap_perr", 64'(perr_w), 64'd1);
    check_val("overlap_missed", 64'(missed_w), 64'd1);
    $display("txn overlap high %0d perr %0d missed %0d", hi, perr_w, missed_w);

    // Overflow: delay 1000, six edges two cycles apart
    program_regs(1000, 1);
    for (int k = 0; k < 12; k++) begin
      inp_r = (k % 2 == 0);
      tick();
    end
    inp_r = 1'b0;
    check_val("ovf_flag", 64'(ovf_w), 64'd1);
    check_val("ovf_missed", 64'(missed_w), 64'd2);
    check_val("ovf_queued", 64'(queued_w), 64'(QD));
    $display("txn overflow queued %0d missed %0d", queued_w, missed_w);

    // Width strobe flushes the queue and clears the errors
    wwstb_r = 1'b1;
    tick();
    wwstb_r = 1'b0;
    check_val("flush_queued", 64'(queued_w), 64'd0);
    check_val("flush_ovf", 64'(ovf_w), 64'd0);
    check_val("flush_missed", 64'(missed_w), 64'd0);
    hi = 0;
    for (int k = 0; k < 1100; k++) begin
      tick();
      if (out_w === 1'b1) hi++;
    end
    check_val("flush_no_pulse", 64'(hi), 64'd0);
    $display("txn flush queued %0d pulses_after %0d", queued_w, hi);

    // Reset in the middle of a pulse, with a second entry still pending
    program_regs(20, 3);
    for (int k = 0; k < 21; k++) begin
      inp_r = (k == 0) || (k == 4);
      tick();
    end
    check_val("midrst_pre_out", 64'(out_w), 64'd1);
    reset_r = 1'b1;
    tick();
    reset_r = 1'b0;
    check_val("midrst_out", 64'(out_w), 64'd0);
    check_val("midrst_queued", 64'(queued_w), 64'd0);
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_w === 1'b1) hi++;
    end
    check_val("midrst_stale", 64'(hi), 64'd0);
    $display("txn mid_pulse_reset stale_pulses %0d", hi);

    // Randomized segments against the model
    for (int s = 0; s < 16; s++) begin
      int d;
      int w;
      int rate;
      int len;
      d = ($urandom_range(0, 5) == 0) ? int'($urandom_range(900, 1023)) : int'($urandom_range(0, 60));
      w = $urandom_range(0, 16);
      rate = $urandom_range(5, 60);
      len = d + 250;
      program_regs(d, w);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) < rate) inp_r = ~inp_r;
        enable_r = ($urandom_range(0, 199) != 0);
        dwstb_r  = ($urandom_range(0, 399) == 0);
        wwstb_r  = ($urandom_range(0, 399) == 0);
        reset_r  = ($urandom_range(0, 599) == 0);
        tick();
      end
      enable_r = 1'b1;
      dwstb_r = 1'b0;
      wwstb_r = 1'b0;
      reset_r = 1'b0;
      $display("txn seg %0d delay %0d width %0d rate %0d checks %0d", s, d, w, rate, checks);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
